// File: rtl/execute_unit.sv
// RV32IM execute stage: ALU, single-cycle multiplier, iterative divider
// and the EX/MEM pipeline register.
module execute_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [2:0]  LoadControlE,
  input  logic [2:0]  ResultSrcE,
  input  logic [4:0]  ALUControlE,
  input  logic        ALUSrcE,
  input  logic [4:0]  rdE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [2:0]  LoadControlM,
  output logic [2:0]  ResultSrcM,
  output logic [4:0]  rdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] PCTargetM,
  output logic        StallE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic [31:0] src_a, src_b;
  logic [4:0]  shamt;
  logic        is_div, sgn_div, is_rem;
  logic        div0, ovf;
  logic [32:0] trial, diff;
  logic [31:0] div_res;
  logic [31:0] alu_res;
  logic        stall;

  logic signed [32:0] ma, mb;
  logic signed [65:0] prod;
  logic               unused_prod;

  assign src_a = RD1E;
  assign src_b = ALUSrcE ? ImmExtE : RD2E;
  assign shamt = src_b[4:0];

  assign is_div  = (ALUControlE >= 5'd14) && (ALUControlE <= 5'd17);
  assign sgn_div = (ALUControlE == 5'd14) || (ALUControlE == 5'd16);
  assign is_rem  = (ALUControlE == 5'd16) || (ALUControlE == 5'd17);
  assign div0    = (src_b == 32'h0);
  assign ovf     = sgn_div && (src_a == 32'h8000_0000)
                   && (src_b == 32'hFFFF_FFFF);

  // One 33x33 signed multiplier covers all signedness combinations
  assign ma = {(ALUControlE != 5'd13) & src_a[31], src_a};
  assign mb = {((ALUControlE == 5'd10) || (ALUControlE == 5'd11))
               & src_b[31], src_b};
  assign prod = ma * mb;
  assign unused_prod = ^prod[65:64];

  // Restoring step: shift next dividend bit into the partial remainder
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  // Divider result: special cases come straight from the held E operands
  always_comb begin
    div_res = 32'h0;
    if (div0)
      div_res = is_rem ? src_a : 32'hFFFF_FFFF;
    else if (ovf)
      div_res = is_rem ? 32'h0 : 32'h8000_0000;
    else if (is_rem)
      div_res = rneg_q ? (32'h0 - rem_q) : rem_q;
    else
      div_res = qneg_q ? (32'h0 - quo_q) : quo_q;
  end

  // ALU result select; unused codes give zero
  always_comb begin
    alu_res = 32'h0;
    case (ALUControlE)
      5'd0:  alu_res = src_a + src_b;
      5'd1:  alu_res = src_a - src_b;
      5'd2:  alu_res = src_a & src_b;
      5'd3:  alu_res = src_a | src_b;
      5'd4:  alu_res = src_a ^ src_b;
      5'd5:  alu_res = src_a << shamt;
      5'd6:  alu_res = src_a >> shamt;
      5'd7:  alu_res = $unsigned($signed(src_a) >>> shamt);
      5'd8:  alu_res = {31'h0, $signed(src_a) < $signed(src_b)};
      5'd9:  alu_res = {31'h0, src_a < src_b};
      5'd10: alu_res = prod[31:0];
      5'd11: alu_res = prod[63:32];
      5'd12: alu_res = prod[63:32];
      5'd13: alu_res = prod[63:32];
      5'd14: alu_res = div_res;
      5'd15: alu_res = div_res;
      5'd16: alu_res = div_res;
      5'd17: alu_res = div_res;
      default: alu_res = 32'h0;
    endcase
  end

  // Divider FSM next-state, datapath update and stall generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (is_div) begin
          stall = 1'b1;
          if (div0 || ovf) begin
            state_d = S_DONE;
          end else begin
            quo_d   = (sgn_div && src_a[31]) ? (32'h0 - src_a) : src_a;
            dvs_d   = (sgn_div && src_b[31]) ? (32'h0 - src_b) : src_b;
            rem_d   = 32'h0;
            qneg_d  = sgn_div && (src_a[31] ^ src_b[31]);
            rneg_d  = sgn_div && src_a[31];
            cnt_d   = 6'd0;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign StallE = stall & ~RST;

  // Divider state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      quo_q   <= 32'h0;
      rem_q   <= 32'h0;
      dvs_q   <= 32'h0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // EX/MEM register: bubble while stalled, otherwise load the instruction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST || stall) begin
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      LoadControlM <= 3'h0;
      ResultSrcM   <= 3'h0;
      rdM          <= 5'h0;
      ALUResultM   <= 32'h0;
      WriteDataM   <= 32'h0;
      PCPlus4M     <= 32'h0;
      PCTargetM    <= 32'h0;
    end else begin
      RegWriteM    <= RegWriteE;
      MemWriteM    <= MemWriteE;
      LoadControlM <= LoadControlE;
      ResultSrcM   <= ResultSrcE;
      rdM          <= rdE;
      ALUResultM   <= alu_res;
      WriteDataM   <= RD2E;
      PCPlus4M     <= PCPlus4E;
      PCTargetM    <= PCE + ImmExtE;
    end
  end

endmodule
